accu_job_scheduler: RTL and testbench



---
 rtl/accu_job_scheduler.sv | 159 +++++++++++++++
 tb/tb_accu_job_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/accu_job_scheduler.sv
// ---------------------------------------------------------------------------
// accu_job_scheduler
//
// Round-robin scheduler that shares a single Accumulator between NUM_REQ
// requesters. One requester owns the accumulator at a time. While it owns it,
// the scheduler holds accu_en high, follows accu_finished through its
// low-then-high sequence, and then drops accu_en for one cycle so the
// accumulator returns to step 0 with its sum cleared. Each job is reported
// back to its owner as a one-cycle done pulse. err accompanies the pulse when
// a programmable cycle budget ran out before the accumulator finished.
//
// Ports
//   sys_clk        clock, shared with the Accumulator
//   sys_rst_n      asynchronous active-low reset
//   req            level job request per requester
//   grant          one-hot owner of the current job, 0 when idle
//   done           one-cycle completion pulse to the owner
//   err            qualifies done: 1 = job ended by timeout
//   busy           1 in every state except IDLE
//   timeout_limit  cycle budget per job, 0 = no timeout; sampled at grant
//   accu_en        enable to the Accumulator
//   accu_finished  finished flag from the Accumulator (1 when idle)
//   job_cnt        completed jobs including timed-out ones, wraps at 16 bits
//   fsm_state      current FSM state (debug observation)
//
// Request handshake: a requester raises req and holds it until it sees its
// done bit. req is only looked at in IDLE, so dropping it mid-job has no
// effect. grant marks the owner from the cycle after selection through the
// last RUN cycle. done and err are valid for exactly one cycle (RELEASE);
// the requester must drop req no later than the cycle after done, otherwise
// it is granted again.
// ---------------------------------------------------------------------------
module accu_job_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 busy,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic                 accu_en,
    input  logic                 accu_finished,
    output logic [15:0]          job_cnt,
    output logic [1:0]           fsm_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]           state;
    logic [PTR_W-1:0]     ptr;
    logic [TIMEOUT_W-1:0] limit_q;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    logic                 found;
    logic [PTR_W-1:0]     sel;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic                 tmo_hit;
    logic                 to_release;
    logic                 err_next;

    // Search req starting at ptr and wrapping; the first set bit wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign ptr_next   = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    assign sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;

    // The counter equals the number of cycles spent since grant, so a hit
    // on cycle grant+limit puts RELEASE at grant+limit+1.
    assign tmo_hit = (limit_q != '0) && (tmo_cnt == limit_q);

    // Timeout wins over a finished flag arriving in the same cycle.
    always_comb begin
        to_release = 1'b0;
        err_next   = 1'b0;
        if (state == ST_ARM || state == ST_RUN) begin
            if (tmo_hit) begin
                to_release = 1'b1;
                err_next   = 1'b1;
            end else if (state == ST_RUN && accu_finished) begin
                to_release = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            limit_q <= '0;
            tmo_cnt <= '0;
            grant   <= '0;
            done    <= '0;
            err     <= 1'b0;
            job_cnt <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant   <= sel_onehot;
                        limit_q <= timeout_limit;
                        tmo_cnt <= '0;
                        ptr     <= ptr_next;
                        state   <= ST_ARM;
                    end
                end
                ST_ARM, ST_RUN: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (to_release) begin
                        done    <= grant;
                        err     <= err_next;
                        grant   <= '0;
                        job_cnt <= job_cnt + 16'd1;
                        state   <= ST_RELEASE;
                    end else if (state == ST_ARM && !accu_finished) begin
                        // Accumulator has left idle: the job is running.
                        state <= ST_RUN;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Derived from the state register so that reset removes accu_en
    // immediately and the accumulator aborts along with the scheduler.
    assign accu_en   = (state == ST_ARM) || (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_accu_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_accu_job_scheduler
//
// Bench for accu_job_scheduler (NUM_REQ=4, TIMEOUT_W=16) with a small
// behavioural Accumulator: when accu_en rises it drops finished on the next
// cycle, keeps it low for run_len cycles (forever if run_len is 0) and
// raises it again; accu_en low returns it to idle with finished high.
// ---------------------------------------------------------------------------
module tb_accu_job_scheduler;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        err;
    logic        busy;
    logic [15:0] timeout_limit;
    logic        accu_en;
    logic        accu_finished;
    logic [15:0] job_cnt;
    logic [1:0]  fsm_state;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt;

    // ---------------- clock / reset ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    accu_job_scheduler #(.NUM_REQ(4), .TIMEOUT_W(16)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .req           (req),
        .grant         (grant),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .timeout_limit (timeout_limit),
        .accu_en       (accu_en),
        .accu_finished (accu_finished),
        .job_cnt       (job_cnt),
        .fsm_state     (fsm_state)
    );

    // ---------------- accumulator model ----------------
    int   run_len;
    logic started;
    int   mcnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            accu_finished <= 1'b1;
            started       <= 1'b0;
            mcnt          <= 0;
        end else if (!accu_en) begin
            accu_finished <= 1'b1;
            started       <= 1'b0;
            mcnt          <= 0;
        end else if (!started) begin
            accu_finished <= 1'b0;
            started       <= 1'b1;
            mcnt          <= 1;
        end else if (!accu_finished && run_len != 0) begin
            if (mcnt == run_len) accu_finished <= 1'b1;
            else                 mcnt <= mcnt + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One job: add request bits, wait for grant, follow it to done, drop
    // the finished requester's req in the done cycle. Returns at the
    // falling edge inside the done cycle.
    task automatic run_job(input logic [3:0] add, input logic [15:0] lim, input int run,
                           input logic [3:0] exp_g, input logic exp_e, input int exp_lat,
                           input bit chk_gap);
        int   n;
        logic bad_hold;
        logic bad_err;
        logic [3:0] g;
        timeout_limit = lim;
        run_len       = run;
        req           = req | add;
        n = 0;
        while (grant == 4'b0000 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        if (chk_gap) check("grant_gap", n, 2);
        g = grant;
        check("grant", g, exp_g);
        n        = 0;
        bad_hold = 1'b0;
        bad_err  = 1'b0;
        while (done == 4'b0000 && n < exp_lat + 50) begin
            if (grant !== g || accu_en !== 1'b1 || busy !== 1'b1) bad_hold = 1'b1;
            if (err !== 1'b0) bad_err = 1'b1;
            @(negedge sys_clk);
            n++;
        end
        check("grant_en_hold", bad_hold, 1'b0);
        check("err_without_done", bad_err, 1'b0);
        check("latency", n, exp_lat);
        check("done", done, exp_g);
        check("err", err, exp_e);
        check("release_en", accu_en, 1'b0);
        check("release_grant", grant, 4'b0000);
        exp_cnt = exp_cnt + 16'd1;
        check("job_cnt", job_cnt, exp_cnt);
        req = req & ~done;
    endtask

    typedef struct {
        logic [3:0]  add;
        logic [15:0] lim;
        int          run;
        logic [3:0]  g;
        logic        e;
        int          lat;
        bit          gap;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int n;

        // latency = run_len + 2 when finished wins, limit + 1 on timeout
        tbl[0]  = '{4'b0001, 16'd0,  20,    4'b0001, 1'b0, 22,    1'b0}; // single job
        tbl[1]  = '{4'b0010, 16'd50, 0,     4'b0010, 1'b1, 51,    1'b1}; // timeout
        tbl[2]  = '{4'b0100, 16'd0,  3,     4'b0100, 1'b0, 5,     1'b1}; // next after timeout
        tbl[3]  = '{4'b1000, 16'd30, 29,    4'b1000, 1'b1, 31,    1'b1}; // collision, timeout wins
        tbl[4]  = '{4'b1111, 16'd0,  5,     4'b0001, 1'b0, 7,     1'b1}; // round robin, ptr 0
        tbl[5]  = '{4'b0000, 16'd0,  5,     4'b0010, 1'b0, 7,     1'b1};
        tbl[6]  = '{4'b0000, 16'd0,  5,     4'b0100, 1'b0, 7,     1'b1};
        tbl[7]  = '{4'b0000, 16'd0,  5,     4'b1000, 1'b0, 7,     1'b1};
        tbl[8]  = '{4'b0101, 16'd0,  5,     4'b0001, 1'b0, 7,     1'b1}; // 0101 from ptr 0
        tbl[9]  = '{4'b0000, 16'd0,  5,     4'b0100, 1'b0, 7,     1'b1};
        tbl[10] = '{4'b0001, 16'd30, 28,    4'b0001, 1'b0, 30,    1'b1}; // finish one cycle early
        tbl[11] = '{4'b0010, 16'd31, 29,    4'b0010, 1'b0, 31,    1'b1}; // limit one above
        tbl[12] = '{4'b0100, 16'd0,  70000, 4'b0100, 1'b0, 70002, 1'b1}; // timeout disabled

        sys_rst_n     = 1'b0;
        req           = 4'b0000;
        timeout_limit = 16'd0;
        run_len       = 0;
        exp_cnt       = 16'd0;
        repeat (3) @(negedge sys_clk);

        check("rst_grant", grant, 4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_accu_en", accu_en, 1'b0);
        check("rst_job_cnt", job_cnt, 16'h0000);
        check("rst_state", fsm_state, 2'd0);

        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        for (int i = 0; i < 13; i++)
            run_job(tbl[i].add, tbl[i].lim, tbl[i].run, tbl[i].g, tbl[i].e, tbl[i].lat, tbl[i].gap);

        // Reset in the middle of a job. Pointer is 1 after granting 0001,
        // so a post-reset request of 0011 reveals whether it went back to 0.
        run_len       = 100;
        timeout_limit = 16'd0;
        req           = 4'b0001;
        n = 0;
        while (grant == 4'b0000 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        check("pre_rst_grant", grant, 4'b0001);
        repeat (10) @(negedge sys_clk);
        check("pre_rst_en", accu_en, 1'b1);
        sys_rst_n = 1'b0;
        req       = 4'b0000;
        #1;
        check("midrst_grant", grant, 4'b0000);
        check("midrst_done", done, 4'b0000);
        check("midrst_err", err, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_accu_en", accu_en, 1'b0);
        check("midrst_job_cnt", job_cnt, 16'h0000);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        exp_cnt   = 16'd0;
        @(negedge sys_clk);
        run_job(4'b0011, 16'd0, 3, 4'b0001, 1'b0, 5, 1'b0);

        // job_cnt wrap: 0010 is still pending and is granted next.
        force dut.job_cnt = 16'hFFFF;
        #1;
        release dut.job_cnt;
        exp_cnt = 16'hFFFF;
        check("forced_job_cnt", job_cnt, 16'hFFFF);
        run_job(4'b0000, 16'd0, 3, 4'b0010, 1'b0, 5, 1'b1);
        check("wrap_job_cnt", job_cnt, 16'h0000);

        repeat (3) @(negedge sys_clk);
        check("final_idle_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
